// File: rtl/tof_digit_assembler_if.sv
`default_nettype none
// ============================================================================
// Module : tof_digit_assembler_if
// Brief  : Code-word input and packed-digit output bundle for the assembler.
// Rev    : 1.0
// ============================================================================
interface tof_digit_assembler_if #(
  parameter int NDIGITS = 4,
  parameter int CNTW    = 8
);
  logic [4:0]           code;
  logic                 det;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*NDIGITS-1:0] digits;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_pulse;
  logic [CNTW-1:0]      err_cnt;
  logic                 cnt_clr;

  modport master (
    output code, det, in_valid, out_ready, cnt_clr,
    input  in_ready, digits, out_valid, err_pulse, err_cnt
  );

  modport slave (
    input  code, det, in_valid, out_ready, cnt_clr,
    output in_ready, digits, out_valid, err_pulse, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tof_digit_assembler.sv
`default_nettype none
// ============================================================================
// Module : tof_digit_assembler
// Brief  : Decodes checked two-out-of-five words and packs NDIGITS BCD digits.
// Rev    : 1.0
// ============================================================================
module tof_digit_assembler #(
  parameter int NDIGITS = 4,
  parameter int CNTW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tof_digit_assembler_if.slave   bus
);
  localparam int              W_DIG    = 4 * NDIGITS;
  localparam int              IDXW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [W_DIG-1:0] shift_q;
  logic [W_DIG-1:0] shift_d;
  logic [W_DIG-1:0] digits_q;
  logic             out_valid_q;
  logic             err_pulse_q;
  logic [CNTW-1:0]  err_cnt_q;

  logic [3:0]       digit;
  logic             code_ok;
  logic             accept;
  logic             good_accept;
  logic             err_accept;

  always_comb begin
    digit   = 4'd0;
    code_ok = 1'b1;
    case (bus.code)
      5'b00011: digit = 4'd1;
      5'b00101: digit = 4'd2;
      5'b00110: digit = 4'd3;
      5'b01001: digit = 4'd4;
      5'b01010: digit = 4'd5;
      5'b01100: digit = 4'd6;
      5'b10001: digit = 4'd7;
      5'b10010: digit = 4'd8;
      5'b10100: digit = 4'd9;
      5'b11000: digit = 4'd0;
      default:  code_ok = 1'b0;
    endcase
  end

  // A code outside the ten legal patterns is an error even if DET missed it.
  assign accept      = bus.in_valid && (state_q == COLLECT);
  assign good_accept = accept && !bus.det && code_ok;
  assign err_accept  = accept && (bus.det || !code_ok);
  assign shift_d     = {shift_q[W_DIG-5:0], digit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      shift_q     <= '0;
      digits_q    <= '0;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_accept;

      if (bus.cnt_clr) begin
        err_cnt_q <= err_accept ? CNTW'(1) : '0;
      end else if (err_accept && (err_cnt_q != CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + CNTW'(1);
      end

      case (state_q)
        COLLECT: begin
          if (good_accept) begin
            shift_q <= shift_d;
            if (idx_q == LAST_IDX) begin
              digits_q    <= shift_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end else if (err_accept) begin
            idx_q   <= '0;
            shift_q <= '0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.digits    = digits_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
`default_nettype wire

// File: doc/tof_digit_assembler.md
Name: tof_digit_assembler

Overview:
- Downstream consumer of the two-out-of-five code checker.
- Accepts one 5-bit two-out-of-five code word per handshake, together with the checker's DET flag (0 = valid, 1 = error).
- Decodes each valid word to a BCD digit and packs NDIGITS digits into a word, which it presents on a valid/ready output.
- Rejects any word flagged by DET, discards the partial word, and keeps a saturating error count.

Parameters:
- NDIGITS, 4: BCD digits per output word (legal range 2..8).
- CNTW, 8: width of the error counter.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CODE  input  5  two-out-of-five code word; bit weights CODE[4]=7, CODE[3]=4, CODE[2]=2, CODE[1]=1, CODE[0]=0.
- DET  input  1  checker result for CODE; 0 = valid, 1 = error.
- IN_VALID  input  1  CODE/DET are valid this cycle.
- IN_READY  output  1  block can accept a word this cycle.
- DIGITS  output  4*NDIGITS  packed BCD word; first-received digit in the most significant nibble.
- OUT_VALID  output  1  DIGITS holds a complete word.
- OUT_READY  input  1  downstream accepts DIGITS.
- ERR_PULSE  output  1  one-cycle pulse, the cycle after an erroneous word is accepted.
- ERR_CNT  output  CNTW  saturating count of erroneous words.
- CNT_CLR  input  1  synchronous clear of ERR_CNT.

Behaviour:
Reset:
- While RST=1 at a clock edge: state=COLLECT, digit index=0, DIGITS=0, OUT_VALID=0, ERR_PULSE=0, ERR_CNT=0, shift register=0.
- RST overrides every other input, including mid-word and mid-HOLD. Any partial or held word is lost.

Handshake and states:
- Input accept = IN_VALID & IN_READY.
- IN_READY is 1 only in COLLECT. It is a combinational decode of registered state only; it does not depend on IN_VALID.
- FSM has two states, COLLECT and HOLD.

Decode (combinational, used only on accept with DET=0):
- Digit = sum of the weights of the set bits, except weight-sum 11 (CODE=11000) decodes to 0.
- Full map: 00011→1, 00101→2, 00110→3, 01001→4, 01010→5, 01100→6, 10001→7, 10010→8, 10100→9, 11000→0.
- DET=0 with a CODE outside this set (checker violation) is treated exactly as DET=1.

COLLECT state:
- Accept with a valid word:
  - The digit shifts into the internal shift register (left shift by 4, new digit in the low nibble).
  - The index increments.
  - When the index reaches NDIGITS-1 before the accept, the completed register is copied to DIGITS on that edge. On the same edge: OUT_VALID←1, state←HOLD, index←0.
  - Output latency: OUT_VALID rises 1 cycle after the last digit is accepted.
- Accept with an error word:
  - Index←0 and the shift register←0 (partial word discarded).
  - ERR_PULSE←1 for exactly one cycle.
  - ERR_CNT increments, saturating at 2^CNTW-1.
  - State stays COLLECT.
  - An error on the last digit of a word also discards the word, and OUT_VALID stays 0.
- No accept: all state holds.

HOLD state:
- DIGITS and OUT_VALID are stable until OUT_READY=1.
- On the edge with OUT_READY=1: OUT_VALID←0, state←COLLECT.
- IN_READY=0 throughout HOLD, including the cycle OUT_READY is high.
- Minimum period per output word = NDIGITS+1 cycles.
- DIGITS retains its last value after release; it is updated only on completion of a word.

Counter:
- CNT_CLR=1 zeroes ERR_CNT.
- If CNT_CLR and an error accept occur in the same cycle, ERR_CNT←1.
- At saturation, further errors leave ERR_CNT unchanged. ERR_PULSE still fires.

Glitch-free outputs:
- All outputs except IN_READY are registered.

Test Plan:
1. Reset, then 4 back-to-back accepts of CODE=00011, 00101, 00110, 01001 with DET=0 and OUT_READY=0 → OUT_VALID rises 1 cycle after the 4th accept with DIGITS=16'h1234. IN_READY=0 while OUT_READY stays 0. Raising OUT_READY → OUT_VALID=0 and IN_READY=1 on the next cycle.
2. Accept CODE=11000, 10100, 10001, 10010 (DET=0) → DIGITS=16'h0978; ERR_CNT=0.
3. Accept digits 1, 2, then a word with DET=1, then 4, 5, 6, 7 → ERR_PULSE high for exactly 1 cycle after the error, ERR_CNT=1, DIGITS=16'h4567 (the 1, 2 partial word is discarded).
4. Accept DET=0 with CODE=00111 (three ones) as the 3rd digit → handled as an error: ERR_CNT increments, index resets, no output word.
5. With CNTW=2, inject 5 error words → ERR_CNT sticks at 3 and ERR_PULSE fires 5 times. Assert CNT_CLR in the same cycle as a 6th error accept → ERR_CNT=1.
6. Assert RST after 3 digits accepted, and again while in HOLD → the next cycle shows OUT_VALID=0, IN_READY=1, DIGITS=0. A fresh 4-digit sequence then produces only those 4 digits.
